// File: rtl/mult_booth_radix_4_seq_if.sv
// Operand/product handshake bundle for mult_booth_radix_4_seq.
// The master drives operands and accepts the product; the slave is the multiplier.
interface mult_booth_radix_4_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      i_valid;
    logic                      o_ready;
    logic                      i_signed;
    logic [DATA_WIDTH-1:0]     iv_a;
    logic [DATA_WIDTH-1:0]     iv_b;
    logic                      o_valid;
    logic                      i_ready;
    logic [2*DATA_WIDTH-1:0]   ov_prod;

    modport master (
        output i_valid, i_signed, iv_a, iv_b, i_ready,
        input  o_ready, o_valid, ov_prod
    );

    modport slave (
        input  i_valid, i_signed, iv_a, iv_b, i_ready,
        output o_ready, o_valid, ov_prod
    );
endinterface

// File: rtl/mult_booth_radix_4_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit retired per clock.
// Signed or unsigned per operation; valid/ready handshake on both sides.
// Optional build macro MULT_BOOTH_EARLY_EXIT_EN: leave CALC as soon as every
// remaining Booth digit is known to be zero (latency becomes data dependent).
module mult_booth_radix_4_seq #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    mult_booth_radix_4_seq_if.slave   bus
);
    localparam int NUM_DIGITS = DATA_WIDTH / 2 + 1;
    localparam int XW         = 2 * NUM_DIGITS;
    localparam int ACC_W      = 2 * DATA_WIDTH + 2;
    localparam int BW         = DATA_WIDTH + 2;
    localparam int CNT_W      = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [ACC_W-1:0] ACC_ONE    = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    // Multiplier shift register: bit 0 is x(2k-1), bits [2:1] are x(2k+1), x(2k).
    logic [XW:0]              mplr;
    logic [BW-1:0]            mcand;
    logic [ACC_W-1:0]         acc;
    logic [CNT_W-1:0]         digit;
    logic                     ready_q;
    logic                     valid_q;
    logic [2*DATA_WIDTH-1:0]  prod_q;

    logic [ACC_W-1:0]         b_wide;
    logic [ACC_W-1:0]         term;
    logic [ACC_W-1:0]         acc_next;
    logic                     last_digit;

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.ov_prod = prod_q;

    // Booth-recode the current digit, weight it by 4^k and decide whether this is the final digit.
    always_comb begin
        b_wide = {{(ACC_W-BW){mcand[BW-1]}}, mcand};
        term   = '0;
        case (mplr[2:0])
            3'b001, 3'b010: term = b_wide;
            3'b011:         term = b_wide << 1;
            3'b100:         term = ~(b_wide << 1) + ACC_ONE;
            3'b101, 3'b110: term = ~b_wide + ACC_ONE;
            default:        term = '0;
        endcase
        acc_next = acc + (term << {digit, 1'b0});
`ifdef MULT_BOOTH_EARLY_EXIT_EN
        // Once x(2k+1) and every bit above it agree, all later digits recode to zero.
        last_digit = (digit == LAST_DIGIT) || (&mplr[XW:2]) || (~|mplr[XW:2]);
`else
        last_digit = (digit == LAST_DIGIT);
`endif
    end

    // Control FSM with registered handshake outputs and the shift-add datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            mplr    <= '0;
            mcand   <= '0;
            acc     <= '0;
            digit   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        mplr    <= {{(XW-DATA_WIDTH){bus.i_signed & bus.iv_a[DATA_WIDTH-1]}}, bus.iv_a, 1'b0};
                        mcand   <= {{2{bus.i_signed & bus.iv_b[DATA_WIDTH-1]}}, bus.iv_b};
                        acc     <= '0;
                        digit   <= '0;
                        ready_q <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mplr  <= {{2{mplr[XW]}}, mplr[XW:2]};
                    digit <= digit + 1'b1;
                    if (last_digit) begin
                        prod_q  <= acc_next[2*DATA_WIDTH-1:0];
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_booth_radix_4_seq.sv
// Directed testbench for mult_booth_radix_4_seq: a 16-bit instance driven from a
// vector table plus handshake/reset sequences, and a 7-bit instance swept against a*b.
module tb_mult_booth_radix_4_seq;
    logic i_clk;
    logic i_rst;

    int tests_run    = 0;
    int tests_failed = 0;

    mult_booth_radix_4_seq_if #(.DATA_WIDTH(16)) bus16 ();
    mult_booth_radix_4_seq_if #(.DATA_WIDTH(7))  bus7 ();

    mult_booth_radix_4_seq #(.DATA_WIDTH(16)) dut16 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus16.slave)
    );

    mult_booth_radix_4_seq #(.DATA_WIDTH(7)) dut7 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus7.slave)
    );

    // Free-running 100 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case anything hangs.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec16_t;

    vec16_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Offer one 16-bit operation; latency counts the accept edge as edge 1.
    task automatic applyStimulus(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                                 input logic rdy, output logic [31:0] prod, output int edges);
        int waits = 0;
        @(negedge i_clk);
        while (!bus16.o_ready && waits < 20) begin
            @(negedge i_clk);
            waits++;
        end
        bus16.i_signed = sgn;
        bus16.iv_a     = a;
        bus16.iv_b     = b;
        bus16.i_ready  = rdy;
        bus16.i_valid  = 1'b1;
        @(posedge i_clk);
        edges = 1;
        @(negedge i_clk);
        bus16.i_valid  = 1'b0;
        bus16.iv_a     = ~a;
        bus16.iv_b     = ~b;
        bus16.i_signed = ~sgn;
        while (!bus16.o_valid && edges < 40) begin
            @(posedge i_clk);
            edges++;
            @(negedge i_clk);
        end
        prod = bus16.ov_prod;
    endtask

    // Same as applyStimulus for the 7-bit instance, with i_ready held high.
    task automatic applyStimulus7(input logic sgn, input logic [6:0] a, input logic [6:0] b,
                                  output logic [13:0] prod, output int edges);
        int waits = 0;
        @(negedge i_clk);
        while (!bus7.o_ready && waits < 20) begin
            @(negedge i_clk);
            waits++;
        end
        bus7.i_signed = sgn;
        bus7.iv_a     = a;
        bus7.iv_b     = b;
        bus7.i_ready  = 1'b1;
        bus7.i_valid  = 1'b1;
        @(posedge i_clk);
        edges = 1;
        @(negedge i_clk);
        bus7.i_valid = 1'b0;
        while (!bus7.o_valid && edges < 40) begin
            @(posedge i_clk);
            edges++;
            @(negedge i_clk);
        end
        prod = bus7.ov_prod;
    endtask

    initial begin
        logic [31:0] prod;
        logic [13:0] prod7;
        logic [13:0] exp7;
        logic [6:0]  a7;
        logic [6:0]  b7;
        logic [6:0]  blist[6];
        int          edges;
        int          sa;
        int          sb;

        vecs[0]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[3]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[4]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[5]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[6]  = '{1'b0, 16'h7FFF, 16'h8000, 32'h3FFF8000};
        vecs[7]  = '{1'b0, 16'h1234, 16'h5678, 32'h06260060};
        vecs[8]  = '{1'b1, 16'hFFFF, 16'h8000, 32'h00008000};
        vecs[9]  = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[10] = '{1'b1, 16'h0003, 16'hFFF9, 32'hFFFFFFEB};
        vecs[11] = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};

        i_rst = 1'b1;
        bus16.i_valid = 1'b0; bus16.i_signed = 1'b0; bus16.iv_a = '0; bus16.iv_b = '0; bus16.i_ready = 1'b0;
        bus7.i_valid  = 1'b0; bus7.i_signed  = 1'b0; bus7.iv_a  = '0; bus7.iv_b  = '0; bus7.i_ready  = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_ready", bus16.o_ready, 1);
        checkOutput("rst_valid", bus16.o_valid, 0);
        checkOutput("rst_prod",  bus16.ov_prod, 0);
        checkOutput("rst_ready7", bus7.o_ready, 1);
        i_rst = 1'b0;

        // Table-driven 16-bit products and latency.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, prod, edges);
            checkOutput($sformatf("prod16[%0d]", i), prod, vecs[i].exp);
`ifdef MULT_BOOTH_EARLY_EXIT_EN
            checkOutput($sformatf("lat16_max[%0d]", i), edges <= 10, 1);
            if (vecs[i].a == 16'h0003)
                checkOutput($sformatf("lat16_early[%0d]", i), edges, 3);
`else
            checkOutput($sformatf("lat16[%0d]", i), edges, 10);
`endif
        end

        // Back-pressure: hold DONE for 5 cycles while a new operation is offered.
        applyStimulus(1'b0, 16'd5, 16'd6, 1'b0, prod, edges);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid", bus16.o_valid, 1);
            checkOutput("bp_prod",  bus16.ov_prod, 32'd30);
            checkOutput("bp_ready", bus16.o_ready, 0);
            bus16.i_valid  = 1'b1;
            bus16.i_signed = 1'b0;
            bus16.iv_a     = 16'd2;
            bus16.iv_b     = 16'd3;
            @(negedge i_clk);
        end
        bus16.i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_idle_ready", bus16.o_ready, 1);
        checkOutput("bp_idle_valid", bus16.o_valid, 0);
        @(posedge i_clk);
        edges = 1;
        @(negedge i_clk);
        bus16.i_valid = 1'b0;
        while (!bus16.o_valid && edges < 40) begin
            @(posedge i_clk);
            edges++;
            @(negedge i_clk);
        end
        checkOutput("bp_next_prod", bus16.ov_prod, 32'd6);
        checkOutput("bp_next_done", bus16.o_valid, 1);

        // Reset while digit 3 is pending in CALC.
        @(negedge i_clk);
        bus16.i_signed = 1'b0;
        bus16.iv_a     = 16'h1234;
        bus16.iv_b     = 16'h5678;
        bus16.i_valid  = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus16.i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", bus16.o_valid, 0);
        checkOutput("rst_mid_ready", bus16.o_ready, 1);
        checkOutput("rst_mid_prod",  bus16.ov_prod, 0);
        @(negedge i_clk);
        checkOutput("rst_hold_valid", bus16.o_valid, 0);
        i_rst = 1'b0;
        applyStimulus(1'b0, 16'd5, 16'd6, 1'b1, prod, edges);
        checkOutput("after_rst_prod", prod, 32'd30);

        // 7-bit sweep: every multiplier against boundary and random multiplicands.
        blist[0] = 7'h00; blist[1] = 7'h01; blist[2] = 7'h3F;
        blist[3] = 7'h40; blist[4] = 7'h7F; blist[5] = 7'h00;
        for (int ai = 0; ai < 128; ai++) begin
            blist[5] = 7'($urandom_range(127));
            for (int bi = 0; bi < 6; bi++) begin
                for (int s = 0; s < 2; s++) begin
                    a7 = 7'(ai);
                    b7 = blist[bi];
                    sa = (s == 1) ? int'($signed(a7)) : int'(a7);
                    sb = (s == 1) ? int'($signed(b7)) : int'(b7);
                    exp7 = 14'(sa * sb);
                    applyStimulus7(s[0], a7, b7, prod7, edges);
                    checkOutput($sformatf("w7 s=%0d a=%0h b=%0h", s, a7, b7), prod7, exp7);
`ifdef MULT_BOOTH_EARLY_EXIT_EN
                    checkOutput("w7_lat_max", edges <= 5, 1);
`else
                    checkOutput("w7_lat", edges, 5);
`endif
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
